time_display: RTL

TIME_DISPLAY -- requirements
Module: time_display

---
 rtl/time_display_pkg.sv | 43 ++++
 rtl/time_display_seg7_decode.sv | 12 +
 rtl/time_display.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/time_display_pkg.sv
// Shared types and constants for the time_display block: FSM state
// encoding, digit/field geometry, the dash code, the 7-segment pattern
// table and the double-dabble nibble adjust step.
package time_display_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONV_H,
        CONV_M,
        CONV_S,
        COMMIT
    } state_t;

    localparam int DIGITS = 6;
    localparam int HOUR_W = 7;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam logic [3:0] DASH = 4'hF;

    // Segment patterns {g,f,e,d,c,b,a}, active-high. 0-9, then A b C d E,
    // and code F is reserved for the out-of-range dash.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h40
    };

    // One double-dabble correction: add 3 to every BCD nibble that is >= 5
    // so the following left shift carries correctly into the next digit.
    function automatic logic [11:0] add3_adjust(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        for (int i = 0; i < 3; i++) begin
            if (v[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/time_display_seg7_decode.sv
// Combinational nibble to 7-segment decode, driven from the shared table.
module seg7_decode
    import time_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Straight table lookup; code F yields the dash.
    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/time_display.sv
// time_display: converts a binary {hours, minutes, seconds} snapshot to six
// BCD digits with a serial double-dabble engine and multiplexes them onto a
// 6-digit 7-segment display with a toggling colon.
//
// Build option: define TIME_DISPLAY_LZB_EN to blank the H10 digit when it
// holds zero.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for half_sec_pulse to start a conversion
// CONV_H | 7 shift/add-3 cycles on the hours field
// CONV_M | 6 shift/add-3 cycles on the minutes field
// CONV_S | 6 shift/add-3 cycles on the seconds field
// COMMIT | publish all six digits; restart at once if a trigger is pending
module time_display
    import time_display_pkg::*;
#(
    parameter int SCAN_DIV = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [19:0] hms_time,
    input  logic        half_sec_pulse,
    output logic [23:0] bcd_digits,
    output logic        bcd_valid,
    output logic        busy,
    output logic [6:0]  seg,
    output logic [5:0]  digit_an,
    output logic        colon
);

    localparam logic [7:0] SCAN_LAST = 8'(SCAN_DIV - 1);
    localparam logic [2:0] HOUR_LAST = 3'(HOUR_W - 1);
    localparam logic [2:0] MIN_LAST  = 3'(MIN_W - 1);
    localparam logic [2:0] SEC_LAST  = 3'(SEC_W - 1);

    state_t      state;
    state_t      state_nxt;
    logic        start;
    logic        pending;
    logic        shown;

    logic [19:0] snap;
    // {bcd accumulator[11:0], binary shift-out[6:0]}
    logic [18:0] dd;
    logic [18:0] dd_nxt;
    logic [2:0]  bit_cnt;
    logic [23:0] conv_digits;

    logic        hours_over;
    logic        min_over;
    logic        sec_over;

    logic [7:0]  scan_cnt;
    logic [3:0]  sel_nib;
    logic [6:0]  dec_seg;
    logic [6:0]  seg_nxt;

    // Minutes are range-checked on the full 7-bit slot; only the low six
    // bits are converted, which is exact whenever the value is below 60.
    assign hours_over = (snap[19:13] >= 7'd100);
    assign min_over   = (snap[12:6]  >= 7'd60);
    assign sec_over   = (snap[5:0]   >= 6'd60);

    // One double-dabble step: correct the BCD nibbles, then shift the
    // whole accumulator/binary pair left by one.
    assign dd_nxt = {add3_adjust(dd[18:7]), dd[6:0]} << 1;

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state, conversion start and busy.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (half_sec_pulse) begin
                    start     = 1'b1;
                    state_nxt = CONV_H;
                end
            end
            CONV_H: begin
                if (bit_cnt == 3'd0) state_nxt = CONV_M;
            end
            CONV_M: begin
                if (bit_cnt == 3'd0) state_nxt = CONV_S;
            end
            CONV_S: begin
                if (bit_cnt == 3'd0) state_nxt = COMMIT;
            end
            COMMIT: begin
                // A trigger arriving in the COMMIT cycle itself counts as
                // pending, so it is not lost.
                if (pending || half_sec_pulse) begin
                    start     = 1'b1;
                    state_nxt = CONV_H;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Conversion datapath: snapshot, shift engine, per-field digit capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            snap        <= '0;
            dd          <= '0;
            bit_cnt     <= '0;
            conv_digits <= '0;
        end else if (start) begin
            snap    <= hms_time;
            dd      <= {12'd0, hms_time[19:13]};
            bit_cnt <= HOUR_LAST;
        end else begin
            case (state)
                CONV_H: begin
                    if (bit_cnt == 3'd0) begin
                        conv_digits[23:16] <= hours_over ? {DASH, DASH} : dd_nxt[14:7];
                        dd      <= {12'd0, snap[11:6], 1'b0};
                        bit_cnt <= MIN_LAST;
                    end else begin
                        dd      <= dd_nxt;
                        bit_cnt <= bit_cnt - 3'd1;
                    end
                end
                CONV_M: begin
                    if (bit_cnt == 3'd0) begin
                        conv_digits[15:8] <= min_over ? {DASH, DASH} : dd_nxt[14:7];
                        dd      <= {12'd0, snap[5:0], 1'b0};
                        bit_cnt <= SEC_LAST;
                    end else begin
                        dd      <= dd_nxt;
                        bit_cnt <= bit_cnt - 3'd1;
                    end
                end
                CONV_S: begin
                    if (bit_cnt == 3'd0) begin
                        conv_digits[7:0] <= sec_over ? {DASH, DASH} : dd_nxt[14:7];
                    end else begin
                        dd      <= dd_nxt;
                        bit_cnt <= bit_cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Publish digits at COMMIT, track pending trigger, display-enable and colon.
    always_ff @(posedge clock) begin
        if (reset) begin
            bcd_digits <= '0;
            bcd_valid  <= 1'b0;
            shown      <= 1'b0;
            pending    <= 1'b0;
            colon      <= 1'b0;
        end else begin
            bcd_valid <= (state == COMMIT);
            if (state == COMMIT) begin
                bcd_digits <= conv_digits;
                shown      <= 1'b1;
            end
            if (start) begin
                pending <= 1'b0;
            end else if (busy && half_sec_pulse) begin
                pending <= 1'b1;
            end
            if (half_sec_pulse) begin
                colon <= ~colon;
            end
        end
    end

    // Digit scan: hold each anode for SCAN_DIV cycles, rotate H10 -> S1 -> H10.
    always_ff @(posedge clock) begin
        if (reset) begin
            scan_cnt <= '0;
            digit_an <= 6'b100000;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            digit_an <= {digit_an[0], digit_an[5:1]};
        end else begin
            scan_cnt <= scan_cnt + 8'd1;
        end
    end

    // Pick the nibble for the currently selected anode.
    always_comb begin
        sel_nib = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_an[i]) sel_nib = bcd_digits[i*4 +: 4];
        end
    end

    seg7_decode u_seg7_decode (
        .nibble (sel_nib),
        .seg    (dec_seg)
    );

    // Segment value before registering: blank until the first result exists.
    always_comb begin
        seg_nxt = shown ? dec_seg : 7'd0;
`ifdef TIME_DISPLAY_LZB_EN
        if (digit_an[DIGITS-1] && (sel_nib == 4'd0)) seg_nxt = 7'd0;
`else
        seg_nxt = seg_nxt;
`endif
    end

    // Segment output register, one cycle behind the anode select.
    always_ff @(posedge clock) begin
        if (reset) begin
            seg <= '0;
        end else begin
            seg <= seg_nxt;
        end
    end

endmodule
